// File: rtl/snake_pkg.sv
// Command codes and button priority shared by the button queue and the movement state machine.
package snake_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_NADA  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_ARR   = 3'd1;
    localparam logic [CMD_W-1:0] CMD_ABA   = 3'd2;
    localparam logic [CMD_W-1:0] CMD_IZQ   = 3'd3;
    localparam logic [CMD_W-1:0] CMD_DER   = 3'd4;
    localparam logic [CMD_W-1:0] CMD_PAUSA = 3'd5;

    localparam int N_BOTONES = 5;
    localparam int BTN_ARR   = 0;
    localparam int BTN_ABA   = 1;
    localparam int BTN_IZQ   = 2;
    localparam int BTN_DER   = 3;
    localparam int BTN_PAUSA = 4;

    // Highest priority first.
    localparam int PRIORIDAD [N_BOTONES] = '{BTN_PAUSA, BTN_ARR, BTN_ABA, BTN_IZQ, BTN_DER};

    function automatic logic [CMD_W-1:0] codigo_boton(input int b);
        case (b)
            BTN_ARR:   return CMD_ARR;
            BTN_ABA:   return CMD_ABA;
            BTN_IZQ:   return CMD_IZQ;
            BTN_DER:   return CMD_DER;
            BTN_PAUSA: return CMD_PAUSA;
            default:   return CMD_NADA;
        endcase
    endfunction

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser followed by a debounce counter that yields the stable level of one button.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic boton,
    output logic estable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            estable <= 1'b0;
        end else begin
            sync_p0 <= boton;
            sync_p1 <= sync_p0;
            // Any sample agreeing with the stable level restarts the count.
            if (sync_p1 == estable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                estable <= sync_p1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cola_comandos_botones.sv
// Debounced buttons -> press flags -> priority serialiser with duplicate filter -> show-ahead command FIFO.
module cola_comandos_botones
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arriba,
    input  logic                       abajo,
    input  logic                       izquierda,
    input  logic                       derecha,
    input  logic                       pausa,
    input  logic                       pop,
    output logic [CMD_W-1:0]           cmd,
    output logic                       cmd_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [N_BOTONES-1:0] botones;
    logic [N_BOTONES-1:0] estable;
    logic [N_BOTONES-1:0] estable_prev;
    logic [N_BOTONES-1:0] pendiente;

    assign botones = {pausa, derecha, izquierda, abajo, arriba};

    for (genvar b = 0; b < N_BOTONES; b++) begin : g_btn
        antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
            .clk    (clk),
            .rst    (rst),
            .boton  (botones[b]),
            .estable(estable[b])
        );
    end

    logic                 hay_sel;
    logic [CMD_W-1:0]     cod_sel;
    logic [N_BOTONES-1:0] sel_mask;

    // Walk from lowest to highest priority so the highest pending flag wins.
    always_comb begin
        hay_sel  = 1'b0;
        cod_sel  = CMD_NADA;
        sel_mask = '0;
        for (int i = N_BOTONES - 1; i >= 0; i--) begin
            if (pendiente[PRIORIDAD[i]]) begin
                hay_sel  = 1'b1;
                cod_sel  = codigo_boton(PRIORIDAD[i]);
                sel_mask = N_BOTONES'(1) << PRIORIDAD[i];
            end
        end
    end

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_sig;
    logic [CMD_W-1:0] last_code;
    logic             lleno;
    logic             pop_ok;
    logic             duplicado;
    logic             push_ok;
    logic             descarte;
    logic [LVL_W-1:0] level_n;
    logic [CMD_W-1:0] cmd_n;

    assign lleno     = (level == LVL_W'(DEPTH));
    assign pop_ok    = pop && (level != '0);
    assign duplicado = hay_sel && (cod_sel != CMD_PAUSA) && (cod_sel == last_code);
    assign push_ok   = hay_sel && !duplicado && (!lleno || pop_ok);
    assign descarte  = hay_sel && !duplicado && lleno && !pop_ok;
    assign rd_sig    = rd_ptr + 1'b1;

    // Next occupancy and next head, so cmd/cmd_valid/full can all be registered.
    always_comb begin
        level_n = level;
        if (push_ok && !pop_ok) begin
            level_n = level + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_n = level - 1'b1;
        end

        cmd_n = cmd;
        if (level_n == '0) begin
            cmd_n = CMD_NADA;
        end else if (pop_ok) begin
            cmd_n = (level == LVL_W'(1)) ? cod_sel : mem[rd_sig];
        end else if (level == '0) begin
            cmd_n = cod_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= cod_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estable_prev <= '0;
            pendiente    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            last_code    <= CMD_NADA;
            level        <= '0;
            cmd          <= CMD_NADA;
            cmd_valid    <= 1'b0;
            full         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            estable_prev <= estable;
            pendiente    <= (pendiente & ~sel_mask) | (estable & ~estable_prev);
            if (push_ok) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_code <= cod_sel;
            end
            if (pop_ok) begin
                rd_ptr <= rd_sig;
            end
            if (descarte) begin
                overflow <= 1'b1;
            end
            level     <= level_n;
            cmd       <= cmd_n;
            cmd_valid <= (level_n != '0);
            full      <= (level_n == LVL_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_cola_comandos_botones.sv
// Randomised and directed bench for cola_comandos_botones with a queue-based reference model and scoreboard.
module tb_cola_comandos_botones;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic       pop;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    cola_comandos_botones #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .arriba   (btn[0]),
        .abajo    (btn[1]),
        .izquierda(btn[2]),
        .derecha  (btn[3]),
        .pausa    (btn[4]),
        .pop      (pop),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: button index 0..4 = arriba, abajo, izquierda, derecha, pausa.
    logic [4:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_prev = '0, m_pend = '0;
    int         m_cnt [5];
    int         m_fifo [$];
    int         m_last = 0;
    logic       m_ovf = 1'b0;
    int         exp_q [$];

    task automatic model_step();
        int   sel;
        int   code;
        bit   pop_ok;
        bit   do_push;
        logic [4:0] new_pend;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_prev = '0; m_pend = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_fifo.delete();
            exp_q.delete();
            m_last = 0;
            m_ovf  = 1'b0;
            return;
        end
        sel = -1;
        if (m_pend[4]) sel = 4;
        else for (int i = 0; i < 4; i++) if (m_pend[i] && sel < 0) sel = i;
        pop_ok   = pop && (m_fifo.size() > 0);
        do_push  = 1'b0;
        code     = 0;
        new_pend = m_pend;
        if (sel >= 0) begin
            new_pend[sel] = 1'b0;
            code = (sel == 4) ? 5 : sel + 1;
            if (code != 5 && code == m_last) ;
            else if (m_fifo.size() == DEPTH && !pop_ok) m_ovf = 1'b1;
            else do_push = 1'b1;
        end
        if (pop_ok) void'(m_fifo.pop_front());
        if (do_push) begin
            m_fifo.push_back(code);
            exp_q.push_back(code);
            m_last = code;
        end
        new_pend = new_pend | (m_st & ~m_prev);
        m_prev   = m_st;
        for (int b = 0; b < 5; b++) begin
            if (m_s2[b] == m_st[b]) m_cnt[b] = 0;
            else if (m_cnt[b] == D - 1) begin m_st[b] = m_s2[b]; m_cnt[b] = 0; end
            else m_cnt[b]++;
        end
        m_s2   = m_s1;
        m_s1   = btn;
        m_pend = new_pend;
    endtask

    // Drive one cycle: inputs change 1 time unit after the edge; the model advances on the edge.
    task automatic tick(input logic [4:0] b, input logic p, input logic r);
        btn = b;
        pop = p;
        rst = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(5'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [4:0] b, input int hold);
        for (int i = 0; i < hold; i++) tick(b, 1'b0, 1'b0);
        idle(8);
    endtask

    // Monitor: full output vector every cycle, and head command against the scoreboard on each pop.
    always @(negedge clk) begin
        int exp_cmd;
        exp_cmd = (m_fifo.size() > 0) ? m_fifo[0] : 0;
        chk("outputs", {23'd0, cmd, cmd_valid, full, level, overflow},
            {23'd0, 3'(exp_cmd), m_fifo.size() != 0, m_fifo.size() == DEPTH,
             3'(m_fifo.size()), m_ovf});
        if (!rst && pop && cmd_valid) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'(cmd), 32'hdead);
            else chk("sb_cmd", 32'(cmd), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        btn = '0; pop = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(5'b0, 1'b0, 1'b1);
        chk("reset_state", {cmd, cmd_valid, full, level, overflow}, 9'd0);

        // Clean derecha press: nothing after edge 7, entry after edge 8.
        for (int i = 0; i < 7; i++) tick(5'b01000, 1'b0, 1'b0);
        chk("latency_early", {cmd_valid, 3'(cmd)}, 4'b0000);
        tick(5'b01000, 1'b0, 1'b0);
        chk("latency_edge8", {cmd_valid, 3'(cmd), level}, {1'b1, 3'd4, 3'd1});
        for (int i = 0; i < 12; i++) tick(5'b01000, 1'b0, 1'b0);
        tick(5'b0, 1'b1, 1'b0);
        chk("pop_to_empty", {cmd_valid, cmd, level}, 7'd0);
        idle(10);

        // Bouncing derecha, then held.
        tick(5'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 5'b01000 : 5'b0, 1'b0, 1'b0);
        press(5'b01000, 15);
        chk("bounce_one", {cmd, level}, {3'd4, 3'd1});

        // Simultaneous arriba + izquierda.
        tick(5'b0, 1'b0, 1'b1);
        press(5'b00101, 12);
        chk("simul_level", {cmd, level}, {3'd1, 3'd2});
        tick(5'b0, 1'b1, 1'b0);
        tick(5'b0, 1'b1, 1'b0);
        idle(2);

        // Duplicate filter and pausa exemption.
        tick(5'b0, 1'b0, 1'b1);
        press(5'b00001, 8);
        press(5'b00001, 8);
        chk("dup_dropped", level, 3'd1);
        press(5'b10000, 8);
        press(5'b10000, 8);
        chk("pausa_twice", level, 3'd3);

        // Fill, overflow, push coinciding with pop, reset.
        tick(5'b0, 1'b0, 1'b1);
        press(5'b00001, 8);
        press(5'b00100, 8);
        press(5'b00010, 8);
        press(5'b01000, 8);
        chk("fill_full", {full, level}, {1'b1, 3'd4});
        press(5'b10000, 8);
        chk("overflow", {overflow, level}, {1'b1, 3'd4});
        for (int i = 0; i < 7; i++) tick(5'b00001, 1'b0, 1'b0);
        tick(5'b00001, 1'b1, 1'b0);
        chk("push_pop_full", {cmd, level}, {3'd3, 3'd4});
        idle(6);
        tick(5'b0, 1'b0, 1'b1);
        chk("rst_clears", {overflow, level}, 4'd0);

        // Pop on empty, then reset mid-debounce.
        for (int i = 0; i < 10; i++) tick(5'b0, 1'b1, 1'b0);
        chk("pop_empty", {cmd, level}, 6'd0);
        for (int i = 0; i < 3; i++) tick(5'b01000, 1'b0, 1'b0);
        tick(5'b0, 1'b0, 1'b1);
        idle(20);
        chk("rst_mid_debounce", {cmd_valid, level}, 4'd0);

        // Random phase: slowly changing buttons, random pops, rare resets.
        begin
            logic [4:0] cur;
            cur = '0;
            for (int i = 0; i < 1500; i++) begin
                for (int b = 0; b < 5; b++)
                    if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
                tick(cur, $urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0);
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
